// File: rtl/colorshield_pkg.sv
// Shared encodings for the colorshield trigger sampler.
package colorshield_pkg;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_OFF  = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/trigger_edge_detector.sv
// Synchronizes trig into clk and flags the selected edge as a one-cycle event.
module trigger_edge_detector
    import colorshield_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig,
    input  logic [1:0] edge_mode,
    output logic       evt
);

    logic trig_s;
    logic trig_q;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign trig_s = trig;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= trig;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign trig_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig_s;
        end
    end

    // Decoded every cycle from the live mode, so a mode change alone cannot fire.
    always_comb begin
        evt = 1'b0;
        case (edge_mode)
            EDGE_RISE: evt = trig_s & ~trig_q;
            EDGE_FALL: evt = ~trig_s & trig_q;
            EDGE_BOTH: evt = trig_s ^ trig_q;
            default:   evt = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_channel_sampler.sv
// Captures CHANNELS data words on a trigger edge and holds them behind valid/ready.
//   state    | meaning
//   ST_EMPTY | no sample held, out_valid=0
//   ST_FULL  | sample held until the consumer pops it, out_valid=1
module multi_channel_sampler
    import colorshield_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int OVERWRITE   = 0,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      trig,
    input  logic [1:0]                edge_mode,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic [CHANNELS*WIDTH-1:0] data,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          overrun_cnt,
    input  logic                      clr_ovr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hold_state_t state;
    logic        evt;
    logic        pop;
    logic        overrun;
    logic        capture;

    trigger_edge_detector #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig),
        .edge_mode(edge_mode),
        .evt      (evt)
    );

    assign pop     = (state == ST_FULL) & out_ready;
    assign overrun = evt & (state == ST_FULL) & ~out_ready;
    assign capture = evt & (~overrun | (OVERWRITE != 0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            out_valid   <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (evt) begin
                state     <= ST_FULL;
                out_valid <= 1'b1;
            end else if (pop) begin
                state     <= ST_EMPTY;
                out_valid <= 1'b0;
            end
            // Clear wins over a coincident overrun increment.
            if (clr_ovr) begin
                overrun_cnt <= '0;
            end else if (overrun && (overrun_cnt != CNT_MAX)) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [WIDTH-1:0] slice_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slice_q <= '0;
                end else if (capture && ch_en[i]) begin
                    slice_q <= data[i*WIDTH +: WIDTH];
                end
            end

            assign out_data[i*WIDTH +: WIDTH] = slice_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_channel_sampler.sv
// Randomized and directed checks of two sampler configurations against a behavioural model.
module tb_multi_channel_sampler;
    import colorshield_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        trig;
    logic [1:0]  edge_mode;
    logic [3:0]  ch_en;
    logic [31:0] data;
    logic        out_ready;
    logic        clr_ovr;

    logic [31:0] out_data0, out_data1;
    logic        out_valid0, out_valid1;
    logic [1:0]  cnt0;
    logic [7:0]  cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    // dut0: two sync stages, drop on overrun, 2-bit counter
    multi_channel_sampler #(
        .WIDTH(8), .CHANNELS(4), .SYNC_STAGES(2), .OVERWRITE(0), .CNT_W(2)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .trig(trig), .edge_mode(edge_mode), .ch_en(ch_en),
        .data(data), .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .overrun_cnt(cnt0), .clr_ovr(clr_ovr)
    );

    // dut1: already-synchronous trigger, overwrite on overrun, 8-bit counter
    multi_channel_sampler #(
        .WIDTH(8), .CHANNELS(4), .SYNC_STAGES(0), .OVERWRITE(1), .CNT_W(8)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .trig(trig), .edge_mode(edge_mode), .ch_en(ch_en),
        .data(data), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .overrun_cnt(cnt1), .clr_ovr(clr_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Behavioural model: trig history sampled at each clock edge, newest first.
    bit          hist[$];
    bit          m_valid [2];
    logic [31:0] m_data  [2];
    int          m_cnt   [2];
    int          sync_n  [2] = '{2, 0};
    int          ow      [2] = '{0, 1};
    int          cmax    [2] = '{3, 255};

    function automatic bit hist_at(int i);
        return (i < hist.size()) ? hist[i] : 1'b0;
    endfunction

    function automatic void model_clear();
        hist.delete();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_cnt[d]   = 0;
        end
    endfunction

    // Advance model and DUTs by one clock; returns 1 ns after the edge.
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            bit now_lvl, prev_lvl, ev, pop;
            now_lvl  = (sync_n[d] == 0) ? trig : hist_at(sync_n[d] - 1);
            prev_lvl = hist_at(sync_n[d]);
            case (edge_mode)
                EDGE_RISE: ev = now_lvl && !prev_lvl;
                EDGE_FALL: ev = !now_lvl && prev_lvl;
                EDGE_BOTH: ev = now_lvl != prev_lvl;
                default:   ev = 1'b0;
            endcase
            pop = m_valid[d] && out_ready;
            if (ev && (!m_valid[d] || pop || ow[d] == 1)) begin
                for (int c = 0; c < 4; c++) begin
                    if (ch_en[c]) m_data[d][c*8 +: 8] = data[c*8 +: 8];
                end
            end
            if (clr_ovr) m_cnt[d] = 0;
            else if (ev && m_valid[d] && !pop && m_cnt[d] < cmax[d]) m_cnt[d]++;
            if (ev) m_valid[d] = 1'b1;
            else if (pop) m_valid[d] = 1'b0;
        end
        @(posedge clk);
        hist.push_front(trig);
        if (hist.size() > 8) void'(hist.pop_back());
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; trig = 1'b0; clr_ovr = 1'b0; out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trig = 1'b0; edge_mode = EDGE_RISE; ch_en = 4'hF;
        data = '0; out_ready = 1'b0; clr_ovr = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if ({out_valid0, out_data0, cnt0} !== 35'd0) begin
            n_fail++; $display("FAIL reset_dut0 got %b/%h/%0d want 0/0/0", out_valid0, out_data0, cnt0);
        end
        n_checks++;
        if ({out_valid1, out_data1, cnt1} !== 41'd0) begin
            n_fail++; $display("FAIL reset_dut1 got %b/%h/%0d want 0/0/0", out_valid1, out_data1, cnt1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_rising();
        edge_mode = EDGE_RISE; ch_en = 4'hF; out_ready = 1'b0;
        data = 32'hA1B2C3D4; trig = 1'b1;
        step();
        n_checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== 32'hA1B2C3D4) begin
            n_fail++; $display("FAIL rise_dut1 got %b/%h want 1/a1b2c3d4", out_valid1, out_data1);
        end
        step();
        n_checks++;
        if (out_valid0 !== 1'b0) begin
            n_fail++; $display("FAIL rise_dut0_early got %b want 0", out_valid0);
        end
        step();
        n_checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== 32'hA1B2C3D4) begin
            n_fail++; $display("FAIL rise_dut0 got %b/%h want 1/a1b2c3d4", out_valid0, out_data0);
        end
        trig = 1'b0;
        repeat (4) step();
        n_checks++;
        if (cnt0 !== 2'd0 || cnt1 !== 8'd0) begin
            n_fail++; $display("FAIL rise_no_fall_event got %0d/%0d want 0/0", cnt0, cnt1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || out_data0 !== 32'hA1B2C3D4) begin
            n_fail++; $display("FAIL rise_pop got %b/%b/%h want 0/0/a1b2c3d4", out_valid0, out_valid1, out_data0);
        end
    endtask

    task automatic test_both_mode();
        int n0 = 0, n1 = 0, first0 = -1, first1 = -1;
        logic [15:0] seq0 = '0, seq1 = '0;
        edge_mode = EDGE_BOTH; ch_en = 4'hF; out_ready = 1'b1;
        data = 32'd1; trig = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (t == 10) begin trig = 1'b0; data = 32'd2; end
            step();
            if (out_valid0) begin
                n0++; seq0 = {seq0[7:0], out_data0[7:0]};
                if (first0 < 0) first0 = t;
            end
            if (out_valid1) begin
                n1++; seq1 = {seq1[7:0], out_data1[7:0]};
                if (first1 < 0) first1 = t;
            end
        end
        out_ready = 1'b0;
        n_checks++;
        if (n0 != 2 || seq0 !== 16'h0102 || first0 != 2) begin
            n_fail++; $display("FAIL both_dut0 got n=%0d seq=%h first=%0d want 2/0102/2", n0, seq0, first0);
        end
        n_checks++;
        if (n1 != 2 || seq1 !== 16'h0102 || first1 != 0) begin
            n_fail++; $display("FAIL both_dut1 got n=%0d seq=%h first=%0d want 2/0102/0", n1, seq1, first1);
        end
    endtask

    task automatic test_ch_en();
        edge_mode = EDGE_RISE; ch_en = 4'hF; out_ready = 1'b1;
        data = 32'h11223344; trig = 1'b1;
        repeat (4) step();
        trig = 1'b0;
        repeat (3) step();
        ch_en = 4'b0101; data = 32'hFFFFFFFF; trig = 1'b1;
        repeat (2) step();
        n_checks++;
        if (out_data1 !== 32'h11FF33FF) begin
            n_fail++; $display("FAIL chen_dut1 got %h want 11ff33ff", out_data1);
        end
        step();
        n_checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== 32'h11FF33FF) begin
            n_fail++; $display("FAIL chen_dut0 got %b/%h want 1/11ff33ff", out_valid0, out_data0);
        end
        trig = 1'b0;
        repeat (3) step();
        out_ready = 1'b0; ch_en = 4'b0000; data = 32'h0; trig = 1'b1;
        repeat (3) step();
        n_checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== 32'h11FF33FF || out_valid1 !== 1'b1) begin
            n_fail++; $display("FAIL chen_zero got %b/%h/%b want 1/11ff33ff/1", out_valid0, out_data0, out_valid1);
        end
        trig = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0; ch_en = 4'hF;
    endtask

    task automatic test_overrun();
        apply_reset();
        edge_mode = EDGE_BOTH; ch_en = 4'hF;
        for (int k = 0; k < 3; k++) begin
            data = 32'd5 + k; trig = ~trig;
            repeat (4) step();
        end
        n_checks++;
        if (out_data0 !== 32'd5 || cnt0 !== 2'd2) begin
            n_fail++; $display("FAIL ovr_drop got %h/%0d want 5/2", out_data0, cnt0);
        end
        n_checks++;
        if (out_data1 !== 32'd7 || cnt1 !== 8'd2) begin
            n_fail++; $display("FAIL ovr_overwrite got %h/%0d want 7/2", out_data1, cnt1);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            data = 32'd8 + k; trig = ~trig;
            repeat (4) step();
        end
        n_checks++;
        if (cnt0 !== 2'd3 || cnt1 !== 8'd5) begin
            n_fail++; $display("FAIL sat_count got %0d/%0d want 3/5", cnt0, cnt1);
        end
        data = 32'd20; trig = ~trig;
        repeat (2) step();
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        step();
        n_checks++;
        if (cnt0 !== 2'd0 || cnt1 !== 8'd0) begin
            n_fail++; $display("FAIL sat_clear got %0d/%0d want 0/0", cnt0, cnt1);
        end
        n_checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== 32'd5) begin
            n_fail++; $display("FAIL sat_clear_data got %b/%h want 1/5", out_valid0, out_data0);
        end
    endtask

    task automatic test_reset_midop();
        int e0 = -1, e1 = -1;
        apply_reset();
        edge_mode = EDGE_RISE; ch_en = 4'hF; data = 32'hAA;
        trig = 1'b1; repeat (3) step();
        trig = 1'b0; repeat (3) step();
        trig = 1'b1; data = 32'hBB; repeat (3) step();
        n_checks++;
        if (out_valid0 !== 1'b1 || cnt0 !== 2'd1 || cnt1 !== 8'd1) begin
            n_fail++; $display("FAIL midop_setup got %b/%0d/%0d want 1/1/1", out_valid0, cnt0, cnt1);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid0, out_data0, cnt0} !== 35'd0 || {out_valid1, out_data1, cnt1} !== 41'd0) begin
            n_fail++; $display("FAIL midop_async got %b/%h/%0d %b/%h/%0d want zeros",
                               out_valid0, out_data0, cnt0, out_valid1, out_data1, cnt1);
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (out_valid0 && e0 < 0) e0 = e;
            if (out_valid1 && e1 < 0) e1 = e;
        end
        n_checks++;
        if (e0 != 3 || e1 != 1) begin
            n_fail++; $display("FAIL midop_latency got %0d/%0d want 3/1", e0, e1);
        end
        n_checks++;
        if (cnt0 !== 2'd0 || cnt1 !== 8'd0 || out_data0 !== 32'hBB) begin
            n_fail++; $display("FAIL midop_single got %0d/%0d/%h want 0/0/bb", cnt0, cnt1, out_data0);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        apply_reset();
        edge_mode = EDGE_BOTH;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(2, 0) == 0) trig = ~trig;
            if ($urandom_range(15, 0) == 0) edge_mode = 2'($urandom_range(3, 0));
            ch_en     = 4'($urandom);
            data      = $urandom;
            out_ready = ($urandom_range(2, 0) == 0);
            clr_ovr   = ($urandom_range(19, 0) == 0);
            step();
            n_checks++;
            if (out_valid0 !== m_valid[0] || out_data0 !== m_data[0] || cnt0 !== m_cnt[0][1:0]) begin
                n_fail++;
                if (shown++ < 10)
                    $display("FAIL rand_dut0 t=%0d got %b/%h/%0d want %b/%h/%0d",
                             t, out_valid0, out_data0, cnt0, m_valid[0], m_data[0], m_cnt[0]);
            end
            n_checks++;
            if (out_valid1 !== m_valid[1] || out_data1 !== m_data[1] || cnt1 !== m_cnt[1][7:0]) begin
                n_fail++;
                if (shown++ < 10)
                    $display("FAIL rand_dut1 t=%0d got %b/%h/%0d want %b/%h/%0d",
                             t, out_valid1, out_data1, cnt1, m_valid[1], m_data[1], m_cnt[1]);
            end
        end
        clr_ovr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rising();
        test_both_mode();
        test_ch_en();
        test_overrun();
        test_saturation();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_sampler.md
# multi_channel_sampler

Parametrised trigger sampler for the colorshield interface. Captures CHANNELS independent WIDTH-bit data words on a selectable edge of a possibly asynchronous trigger, typically shield_ready. Holds the captured words in an output register behind a valid/ready handshake and counts overruns when the consumer is too slow. Sits between the pixel/control generators and the DM163 shift-out logic.

## Interface
Parameters:
- WIDTH, 8, bits per channel
- CHANNELS, 4, number of captured channels
- SYNC_STAGES, 2, synchronizer flops on trig; legal range 0..4, where 0 means trig is already synchronous
- OVERWRITE, 0, on overrun: 1 replaces held data, 0 drops the new sample
- CNT_W, 8, overrun counter width

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- trig  in  1  trigger, may be asynchronous to clk
- edge_mode  in  2  00 rising, 01 falling, 10 both, 11 disabled
- ch_en  in  CHANNELS  per-channel capture enable
- data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]; synchronous to clk
- out_data  out  CHANNELS*WIDTH  held sample
- out_valid  out  1  held sample not yet consumed
- out_ready  in  1  consumer accepts the sample when out_valid & out_ready
- overrun_cnt  out  CNT_W  saturating overrun count
- clr_ovr  in  1  synchronous clear of overrun_cnt

## Operation
- trig passes through SYNC_STAGES flops, producing trig_s. One more flop produces trig_q. All these flops reset to 0.
- The event is combinational on trig_s and trig_q:
  - rising: trig_s & ~trig_q
  - falling: ~trig_s & trig_q
  - both: trig_s ^ trig_q
  - disabled: never
- edge_mode is sampled combinationally each cycle. A mode change never generates an event by itself.
- States are EMPTY (out_valid=0) and FULL (out_valid=1). Pop is out_valid & out_ready.
- Event in EMPTY, or event in FULL with pop in the same cycle: capture. State becomes FULL.
- Event in FULL without pop is an overrun:
  - overrun_cnt increments, saturating at 2^CNT_W-1.
  - If OVERWRITE=1: capture, state stays FULL.
  - If OVERWRITE=0: data is discarded.
- Pop without event: state becomes EMPTY. out_data keeps its value.
- Capture rules:
  - For each i with ch_en[i]=1, the channel-i slice of out_data loads data slice i.
  - Slices with ch_en[i]=0 keep their previous value.
  - A capture with ch_en all zero still sets out_valid. It carries unchanged data.
- clr_ovr has priority over increment. clr_ovr together with an overrun event gives overrun_cnt=0, and the event's data handling still applies.
- Reset values: out_data=0, out_valid=0, overrun_cnt=0, sync/edge flops=0.
- A trig already high at reset release is seen as a rising edge after the sync latency. This is intended.
- Reset mid-operation discards the held sample and the count immediately (asynchronous).

## Timing
- Latency: trig first sampled high at clk edge k makes the event combinational in cycle k+SYNC_STAGES. out_data and out_valid update at edge k+SYNC_STAGES+1. With SYNC_STAGES=0, the event occurs in the same cycle that trig is high, and outputs update at the next edge.
- data is captured exactly at the update edge. There is no synchronization of data; it must be stable in that cycle.
- Minimum trig high/low width is 2 clk periods for each edge to be detected. Narrower pulses may be lost.
- out_ready may depend combinationally on out_valid. No output depends combinationally on out_ready.
- Throughput is one capture per cycle when out_ready is held high.

## Structure
- Package colorshield_pkg holds:
  - EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_OFF=2'b11
- Sub-module trigger_edge_detector contains the SYNC_STAGES synchronizer, trig_q and the mode decode, and outputs the one-bit event.
- The top level holds the capture register, the EMPTY/FULL flag and the overrun counter. Generate loops per channel.

## Test plan
- Rising, CHANNELS=4, WIDTH=8, SYNC_STAGES=2: data=32'hA1B2C3D4, trig 0→1 at edge 10. Required: out_valid=1 and out_data=32'hA1B2C3D4 from edge 13; no event when trig returns to 0.
- Mode both, out_ready=1: trig toggles at edges 10 and 20, data=1 then 2. Required: two captures, at edges 13 and 23, each one cycle valid.
- ch_en=4'b0101, out_data=32'h11223344, new data=32'hFFFFFFFF. Required: out_data=32'h11FF33FF.
- OVERWRITE=0, out_ready=0, three events with data 5, 6, 7. Required: out_data=5, overrun_cnt=2. With OVERWRITE=1: out_data=7, overrun_cnt=2.
- CNT_W=2: five overruns give overrun_cnt=3 (saturated). clr_ovr coincident with a sixth overrun gives 0.
- Reset asserted while FULL with overrun_cnt=1: out_valid, out_data and overrun_cnt are 0 immediately, before any clk edge. Holding trig high through reset release gives one capture after SYNC_STAGES+1 edges.
